// File: rtl/key_schedule_pkg.sv
// Shared widths, FSM state type and the PRESENT 4-bit S-box
// used by the round-key schedule.
package key_schedule_pkg;

  localparam int KEY_W        = 20;
  localparam int RK_W         = 16;
  localparam int RC_W         = 4;
  localparam int NUM_KEYS_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;
      4'h1: y = 4'h5;
      4'h2: y = 4'h6;
      4'h3: y = 4'hB;
      4'h4: y = 4'h9;
      4'h5: y = 4'h0;
      4'h6: y = 4'hA;
      4'h7: y = 4'hD;
      4'h8: y = 4'h3;
      4'h9: y = 4'hE;
      4'hA: y = 4'hF;
      4'hB: y = 4'h8;
      4'hC: y = 4'h4;
      4'hD: y = 4'h7;
      4'hE: y = 4'h1;
      default: y = 4'h2;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/key_schedule_key_update.sv
// One combinational round of the key schedule: rotate left 13,
// S-box the top nibble, fold the round counter into bits [7:4].
module key_update
  import key_schedule_pkg::*;
(
  input  logic [KEY_W-1:0] key,
  input  logic [RC_W-1:0]  rc,
  output logic [KEY_W-1:0] next_key
);

  logic [KEY_W-1:0] rot;

  always_comb begin
    rot      = {key[6:0], key[19:7]};
    next_key = {sbox(rot[19:16]), rot[15:8], rot[7:4] ^ rc, rot[3:0]};
  end

endmodule

// File: rtl/key_schedule.sv
// Round-key generator: issues NUM_KEYS round keys from a 20-bit master
// key over a valid/ready interface, then pulses done for one cycle.
module key_schedule
  import key_schedule_pkg::*;
#(
  parameter int NUM_KEYS = NUM_KEYS_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [KEY_W-1:0]  key_in,
  input  logic              rk_ready,
  output logic              rk_valid,
  output logic [RK_W-1:0]   round_key,
  output logic [3:0]        rk_idx,
  output logic              done
);

  localparam logic [3:0] LAST_IDX = 4'(NUM_KEYS - 1);

  state_t           state;
  logic [KEY_W-1:0] key_reg;
  logic [KEY_W-1:0] next_key;
  logic [3:0]       idx;

  key_update u_key_update (
    .key      (key_reg),
    .rc       (idx + 4'd1),
    .next_key (next_key)
  );

  // Handshake: a key moves on a rising edge where rk_valid and rk_ready are
  // both high; rk_valid never drops while waiting, and the key/index stay
  // frozen until accepted. load overrides everything, even a same-cycle accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      key_reg  <= '0;
      idx      <= '0;
      rk_valid <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_ACTIVE: begin
          if (load) begin
            key_reg  <= key_in;
            idx      <= '0;
            rk_valid <= 1'b1;
          end else if (rk_ready) begin
            if (idx == LAST_IDX) begin
              state    <= ST_DONE;
              rk_valid <= 1'b0;
              done     <= 1'b1;
            end else begin
              key_reg <= next_key;
              idx     <= idx + 4'd1;
            end
          end
        end
        default: begin
          if (load) begin
            state    <= ST_ACTIVE;
            key_reg  <= key_in;
            idx      <= '0;
            rk_valid <= 1'b1;
          end
        end
      endcase
    end
  end

  assign round_key = key_reg[19:4];
  assign rk_idx    = idx;

endmodule

// File: tb/tb_key_schedule.sv
// Self-checking bench for key_schedule: table-driven schedules with a
// scoreboard queue, plus abort, mid-schedule reset and DONE-hold sequences.
module tb_key_schedule;

  localparam int NK = 16;

  logic        clk;
  logic        rst_n;
  logic        load;
  logic [19:0] key_in;
  logic        rk_ready;
  logic        rk_valid;
  logic [15:0] round_key;
  logic [3:0]  rk_idx;
  logic        done;

  int errors;
  int checks;

  logic [19:0] exp_q[$];

  typedef struct {
    logic [19:0] key;
    int          mode;
    logic [15:0] exp_rk0;
    logic [15:0] exp_rk1;
  } vec_t;

  vec_t vecs[4];

  key_schedule #(.NUM_KEYS(NK)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .key_in    (key_in),
    .rk_ready  (rk_ready),
    .rk_valid  (rk_valid),
    .round_key (round_key),
    .rk_idx    (rk_idx),
    .done      (done)
  );

  // Clock / reset defaults
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Golden model: PRESENT-style round written from the algorithm description
  function automatic logic [3:0] model_sbox(input logic [3:0] x);
    logic [63:0] tbl;
    tbl = 64'h21748FE3DA09B65C;
    return tbl[x*4 +: 4];
  endfunction

  function automatic logic [19:0] model_update(input logic [19:0] k, input logic [3:0] rc);
    logic [39:0] dbl;
    logic [19:0] r;
    dbl = {k, k} >> 7;
    r = dbl[19:0];
    r[19:16] = model_sbox(r[19:16]);
    r[7:4] = r[7:4] ^ rc;
    return r;
  endfunction

  // Driver + scoreboard for one complete schedule
  task automatic run_schedule(input logic [19:0] key, input int mode,
                              output logic [15:0] rk0, output logic [15:0] rk1,
                              output int cycles, output logic [19:0] last_exp);
    logic [19:0] k;
    logic [19:0] e;
    logic [15:0] held_rk;
    logic [3:0]  held_idx;
    logic        was_stall;
    int          got;
    exp_q.delete();
    k = key;
    for (int i = 0; i < NK; i++) begin
      exp_q.push_back({i[3:0], k[19:4]});
      k = model_update(k, 4'(i + 1));
    end
    last_exp = exp_q[NK-1];
    @(negedge clk);
    load = 1'b1; key_in = key; rk_ready = 1'b0;
    @(negedge clk);
    load = 1'b0;
    got = 0; cycles = 0; was_stall = 1'b0; rk0 = '0; rk1 = '0;
    while (got < NK && cycles < 200) begin
      if (was_stall) begin
        check("hold_rk", round_key, held_rk);
        check("hold_idx", rk_idx, held_idx);
      end
      check("valid_active", rk_valid, 1'b1);
      check("done_active", done, 1'b0);
      case (mode)
        0:       rk_ready = 1'b1;
        1:       rk_ready = (cycles % 2 == 0);
        default: rk_ready = 1'($urandom_range(0, 1));
      endcase
      if (rk_ready) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("sb_idx_key", {rk_idx, round_key}, e);
        end else begin
          check("sb_underflow", 1, 0);
        end
        if (got == 0) rk0 = round_key;
        if (got == 1) rk1 = round_key;
        got++;
        was_stall = 1'b0;
      end else begin
        was_stall = 1'b1;
        held_rk = round_key;
        held_idx = rk_idx;
      end
      @(negedge clk);
      cycles++;
    end
    check("keys_issued", got, NK);
    check("done_pulse", done, 1'b1);
    check("valid_after_last", rk_valid, 1'b0);
    rk_ready = 1'b0;
    @(negedge clk);
    check("done_single", done, 1'b0);
  endtask

  initial begin
    logic [15:0] rk0, rk1;
    logic [19:0] last_exp;
    int          cyc;
    errors = 0; checks = 0;
    rst_n = 1'b0; load = 1'b0; key_in = '0; rk_ready = 1'b0;

    vecs[0] = '{20'h00000, 0, 16'h0000, 16'hC001};
    vecs[1] = '{20'hFFFFF, 1, 16'hFFFF, 16'h2FFE};
    vecs[2] = '{20'h12345, 2, 16'h1234, 16'h3A25};
    vecs[3] = '{20'h80001, 1, 16'h8000, 16'hC301};

    #3;
    check("rst_valid", rk_valid, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_rk", round_key, 16'h0000);
    check("rst_idx", rk_idx, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;
    rk_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_no_valid", rk_valid, 1'b0);

    for (int v = 0; v < 4; v++) begin
      run_schedule(vecs[v].key, vecs[v].mode, rk0, rk1, cyc, last_exp);
      check("vec_rk0", rk0, vecs[v].exp_rk0);
      check("vec_rk1", rk1, vecs[v].exp_rk1);
      if (vecs[v].mode == 0) check("back_to_back_cycles", cyc, NK);
    end

    // load during a handshake at idx 7 wins
    @(negedge clk);
    load = 1'b1; key_in = 20'h00000; rk_ready = 1'b0;
    @(negedge clk);
    load = 1'b0; rk_ready = 1'b1;
    cyc = 0;
    while (rk_idx != 4'd7 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("abort_reached_idx7", rk_idx, 4'd7);
    load = 1'b1; key_in = 20'h12345;
    @(negedge clk);
    load = 1'b0;
    check("abort_idx", rk_idx, 4'd0);
    check("abort_rk", round_key, 16'h1234);
    check("abort_valid", rk_valid, 1'b1);
    check("abort_no_done", done, 1'b0);
    @(negedge clk);
    check("abort_next_idx", rk_idx, 4'd1);
    check("abort_next_rk", round_key, 16'h3A25);
    check("abort_no_done2", done, 1'b0);
    rk_ready = 1'b0;

    // asynchronous reset at idx 5
    @(negedge clk);
    load = 1'b1; key_in = 20'hFFFFF;
    @(negedge clk);
    load = 1'b0; rk_ready = 1'b1;
    cyc = 0;
    while (rk_idx != 4'd5 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("rst_reached_idx5", rk_idx, 4'd5);
    rk_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", rk_valid, 1'b0);
    check("arst_rk", round_key, 16'h0000);
    check("arst_idx", rk_idx, 4'h0);
    check("arst_done", done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1; rk_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_rst_idle", rk_valid, 1'b0);
    end
    rk_ready = 1'b0;
    run_schedule(20'hABCDE, 2, rk0, rk1, cyc, last_exp);
    check("post_rst_rk0", rk0, 16'hABCD);

    // hold in DONE with rk_ready high, then restart
    run_schedule(20'h5A5A5, 0, rk0, rk1, cyc, last_exp);
    rk_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("done_hold_valid", rk_valid, 1'b0);
      check("done_hold_done", done, 1'b0);
      check("done_hold_state", {rk_idx, round_key}, last_exp);
    end
    rk_ready = 1'b0;
    run_schedule(20'h00000, 1, rk0, rk1, cyc, last_exp);
    check("restart_rk0", rk0, 16'h0000);
    check("restart_rk1", rk1, 16'hC001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
